// File: rtl/mux_8x1_collector_pkg.sv
// Shared lane-tag encoding and collector state for the gather side of the demux_1x8 fan-out.
// Zero latency, no backpressure: declarations only.
package hack_mux_pkg;
    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;

    typedef logic [SEL_W-1:0] lane_sel_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;
endpackage

// File: rtl/mux_8x1_collector_if.sv
// Eight valid/ready input lanes plus one tagged valid/ready output.
// Latency and backpressure are set by the module using it; master drives lanes and ready_in.
interface mux_8x1_collector_if #(parameter int WIDTH = 16);
    import hack_mux_pkg::*;

    logic [NUM_LANES-1:0]            valid_in;
    logic [NUM_LANES-1:0][WIDTH-1:0] data_in;
    logic [NUM_LANES-1:0]            ready_out;
    logic                            valid_out;
    logic [WIDTH-1:0]                data_out;
    lane_sel_t                       sel_out;
    logic                            ready_in;

    modport master (
        output valid_in, data_in, ready_in,
        input  ready_out, valid_out, data_out, sel_out
    );

    modport slave (
        input  valid_in, data_in, ready_in,
        output ready_out, valid_out, data_out, sel_out
    );
endinterface

// File: rtl/mux_8x1_collector_rr_pick_8.sv
// Round-robin picker: first requester at or after ptr, wrapping past lane 7.
// Purely combinational, zero latency, no backpressure.
module rr_pick_8
    import hack_mux_pkg::*;
(
    input  logic [NUM_LANES-1:0] req,
    input  lane_sel_t            ptr,
    output logic [NUM_LANES-1:0] gnt_onehot,
    output lane_sel_t            gnt_idx,
    output logic                 gnt_valid
);
    logic [NUM_LANES-1:0] w_rot;
    lane_sel_t            w_pick;

    // Rotate so that lane ptr lands in bit 0; 3-bit index arithmetic wraps mod 8.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_rot[i] = req[lane_sel_t'(i) + ptr];
        end
    end

    always_comb begin
        w_pick = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_pick = lane_sel_t'(i);
            end
        end
    end

    assign gnt_valid  = |w_rot;
    assign gnt_idx    = w_pick + ptr;
    assign gnt_onehot = gnt_valid ? (NUM_LANES'(1) << gnt_idx) : '0;
endmodule

// File: rtl/mux_8x1_collector.sv
// Eight-lane round-robin collector into one registered, lane-tagged output; one cycle latency.
// Full rate while ready_in=1; a stalled output register drops every ready_out to zero.
module mux_8x1_collector
    import hack_mux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                clk,
    input logic                rst,
    mux_8x1_collector_if.slave bus
);
    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_data;
    lane_sel_t            r_sel;
    lane_sel_t            r_ptr;
    logic [NUM_LANES-1:0] w_gnt_onehot;
    lane_sel_t            w_gnt_idx;
    logic                 w_gnt_valid;
    logic                 w_free;
    logic                 w_take;

    rr_pick_8 u_pick (
        .req        (bus.valid_in),
        .ptr        (r_ptr),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .gnt_valid  (w_gnt_valid)
    );

    // The slot frees up in the same cycle the downstream accepts, so there is no bubble.
    assign w_free = (r_state == ST_EMPTY) || bus.ready_in;
    assign w_take = w_free && w_gnt_valid && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_free) begin
            w_state_nxt = w_gnt_valid ? ST_FULL : ST_EMPTY;
        end
    end

    always_comb begin
        bus.valid_out = (r_state == ST_FULL);
        bus.data_out  = r_data;
        bus.sel_out   = r_sel;
        bus.ready_out = w_take ? w_gnt_onehot : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_sel  <= '0;
            r_ptr  <= '0;
        end else if (w_take) begin
            r_data <= bus.data_in[w_gnt_idx];
            r_sel  <= w_gnt_idx;
            r_ptr  <= w_gnt_idx + lane_sel_t'(1);
        end
    end
endmodule

// File: tb/tb_mux_8x1_collector.sv
// Directed and randomized bench for the eight-lane collector with a transfer scoreboard.
module tb_mux_8x1_collector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_8x1_collector_if #(.WIDTH(16)) bus ();

    mux_8x1_collector #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [18:0] sb[$];
    logic [11:0] wcnt = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Grants are pushed as {lane, word}; output accepts pop in order.
    always @(posedge clk) begin
        logic [18:0] e;
        if (rst) begin
            sb.delete();
        end else begin
            chk("ready_onehot", 32'($onehot0(bus.ready_out)), 32'd1);
            if (bus.valid_out && bus.ready_in) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("sb_sel", 32'(bus.sel_out), 32'(e[18:16]));
                    chk("sb_dat", 32'(bus.data_out), 32'(e[15:0]));
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (bus.valid_in[i] && bus.ready_out[i]) begin
                    sb.push_back({3'(i), bus.data_in[i]});
                end
            end
        end
    end

    initial begin
        logic [7:0] acc;
        bus.valid_in = '1;
        bus.ready_in = 1'b1;
        for (int i = 0; i < 8; i++) bus.data_in[i] = 16'h1000 + 16'(i);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 32'(bus.valid_out), 32'd0);
        chk("rst_dat", 32'(bus.data_out), 32'd0);
        chk("rst_sel", 32'(bus.sel_out), 32'd0);
        chk("rst_rdy", 32'(bus.ready_out), 32'd0);

        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("first_gnt", 32'(bus.ready_out), 32'h01);

        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("full_vld", 32'(bus.valid_out), 32'd1);
            chk("full_sel", 32'(bus.sel_out), 32'(k % 8));
            chk("full_dat", 32'(bus.data_out), 32'h1000 + 32'(k % 8));
        end

        // Backpressure while holding lane 5's word.
        @(posedge clk); #1 bus.valid_in = '0;
        @(posedge clk); #1 bus.valid_in = 8'h20;
        @(posedge clk); #1 bus.ready_in = 1'b0; bus.valid_in = '1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("bp_rdy", 32'(bus.ready_out), 32'd0);
            chk("bp_vld", 32'(bus.valid_out), 32'd1);
            chk("bp_sel", 32'(bus.sel_out), 32'd5);
            chk("bp_dat", 32'(bus.data_out), 32'h1005);
            @(posedge clk); #1;
        end
        bus.ready_in = 1'b1;
        @(negedge clk);
        chk("bp_next", 32'(bus.ready_out), 32'h40);
        @(posedge clk); #1 bus.valid_in = 8'h81;
        @(negedge clk);
        chk("bp_sel6", 32'(bus.sel_out), 32'd6);

        for (int j = 0; j < 4; j++) begin
            chk("wrap_rdy", 32'(bus.ready_out), (j % 2 == 0) ? 32'h80 : 32'h01);
            @(posedge clk); #1;
            @(negedge clk);
            chk("wrap_sel", 32'(bus.sel_out), (j % 2 == 0) ? 32'd7 : 32'd0);
        end

        @(posedge clk); #1 bus.valid_in = 8'h08; bus.data_in[3] = 16'hBEEF;
        @(negedge clk);
        chk("one_rdy", 32'(bus.ready_out), 32'h08);
        @(posedge clk); #1 bus.valid_in = '0;
        @(negedge clk);
        chk("one_vld", 32'(bus.valid_out), 32'd1);
        chk("one_dat", 32'(bus.data_out), 32'hBEEF);
        chk("one_sel", 32'(bus.sel_out), 32'd3);
        chk("one_rdy0", 32'(bus.ready_out), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("one_drop", 32'(bus.valid_out), 32'd0);

        // Reset while the output register is full.
        @(posedge clk); #1 bus.valid_in = '1; bus.data_in[3] = 16'h1003;
        @(posedge clk); #1;
        chk("pre_rst_vld", 32'(bus.valid_out), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_vld", 32'(bus.valid_out), 32'd0);
        chk("mid_rst_dat", 32'(bus.data_out), 32'd0);
        chk("mid_rst_sel", 32'(bus.sel_out), 32'd0);
        chk("mid_rst_rdy", 32'(bus.ready_out), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_gnt", 32'(bus.ready_out), 32'h01);

        for (int c = 0; c < 10000; c++) begin
            acc = bus.valid_in & bus.ready_out;
            @(posedge clk); #1;
            for (int i = 0; i < 8; i++) begin
                if (acc[i]) bus.valid_in[i] = 1'b0;
                if (!bus.valid_in[i] && ($urandom_range(0, 1) == 1)) begin
                    bus.valid_in[i] = 1'b1;
                    bus.data_in[i]  = {4'(i), wcnt};
                    wcnt++;
                end
            end
            bus.ready_in = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end

        bus.valid_in = '0;
        bus.ready_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
